// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
// Holds the FSM state type, the RV32I NOP constant and the index-width helper.
package imem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    // Word-index width for a given depth, never narrower than one bit.
    function automatic int imem_idx_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch and program-load bundle between the PC/decode stages and imem_ctrl.
// master drives requests and load writes, slave is the memory controller.
interface imem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_hold;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;
    logic              ld_we;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              init_done;

    modport master (
        output fetch_req, fetch_addr, fetch_hold, ld_we, ld_addr, ld_data,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, ld_ready, init_done
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_hold, ld_we, ld_addr, ld_data,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, ld_ready, init_done
    );
endinterface

// File: rtl/imem_array.sv
// 1R1W synchronous RAM with registered read and no reset.
// A read and write to the same index on one edge returns the old word.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write and registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: post-reset clear, load port, fetch with range checks.
// Define IMEM_ALIGN_CHECK_EN to also fault fetches whose byte address is not word aligned.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              DEPTH      = 64,
    parameter int              ADDR_W     = 32,
    parameter logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(IMEM_NOP)
) (
    input  logic    clk,
    input  logic    reset_n,
    imem_if.slave   bus
);
    localparam int               IDX_W      = imem_idx_w(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_C    = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DEPTH - 1);

    imem_state_e       state_r;
    logic [IDX_W-1:0]  cnt_r;
    logic              init_done_r;
    logic              ld_ready_r;
    logic              valid_r;
    logic              fault_r;
    logic              have_data_r;

    logic              fetch_ready_s;
    logic              fetch_acc_s;
    logic [IDX_W-1:0]  idx_s;
    logic              upper_nz_s;
    logic              fault_s;
    logic              ld_in_range_s;
    logic              we_s;
    logic [IDX_W-1:0]  waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] instr_s;

    assign fetch_ready_s = ld_ready_r & ~bus.fetch_hold;
    assign fetch_acc_s   = bus.fetch_req & fetch_ready_s;
    assign idx_s         = bus.fetch_addr[IDX_W+1:2];
    assign upper_nz_s    = (bus.fetch_addr >> (IDX_W + 2)) != '0;
    assign ld_in_range_s = {1'b0, bus.ld_addr} < DEPTH_C;

    // Fault decode for the fetch address presented this cycle.
    always_comb begin
        fault_s = upper_nz_s || ({1'b0, idx_s} >= DEPTH_C);
`ifdef IMEM_ALIGN_CHECK_EN
        if (bus.fetch_addr[1:0] != 2'b00) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
`endif
    end

`ifndef IMEM_ALIGN_CHECK_EN
    logic unused_align_s;
    assign unused_align_s = ^bus.fetch_addr[1:0];
`endif

    // Single RAM write port: clear sweep while clearing, load port once ready.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = '0;
        case (state_r)
            CLEAR: begin
                we_s    = 1'b1;
                waddr_s = cnt_r;
                wdata_s = CLEAR_WORD;
            end
            READY: begin
                we_s    = bus.ld_we & ld_in_range_s;
                waddr_s = bus.ld_addr;
                wdata_s = bus.ld_data;
            end
            default: begin
                we_s    = 1'b0;
                waddr_s = '0;
                wdata_s = '0;
            end
        endcase
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .re    (fetch_acc_s & ~fault_s),
        .raddr (idx_s),
        .rdata (rdata_s)
    );

    // Clear/ready sequencer with its registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= CLEAR;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
            ld_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    cnt_r <= cnt_r + IDX_W'(1);
                    if (cnt_r == LAST_IDX_C) begin
                        state_r     <= READY;
                        init_done_r <= 1'b1;
                        ld_ready_r  <= 1'b1;
                    end
                end
                READY: begin
                    state_r     <= READY;
                    init_done_r <= 1'b1;
                    ld_ready_r  <= 1'b1;
                end
                default: begin
                    state_r     <= CLEAR;
                    cnt_r       <= '0;
                    init_done_r <= 1'b0;
                    ld_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Fetch output register: load on accept, drop valid when idle, freeze on hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r     <= 1'b0;
            fault_r     <= 1'b0;
            have_data_r <= 1'b0;
        end else if (fetch_acc_s) begin
            valid_r     <= 1'b1;
            fault_r     <= fault_s;
            have_data_r <= 1'b1;
        end else if (!bus.fetch_hold) begin
            valid_r     <= 1'b0;
        end
    end

    // The RAM read register holds the word itself; faults substitute the clear word.
    always_comb begin
        if (!have_data_r) begin
            instr_s = '0;
        end else if (fault_r) begin
            instr_s = CLEAR_WORD;
        end else begin
            instr_s = rdata_s;
        end
    end

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.fetch_valid = valid_r;
    assign bus.fetch_instr = instr_s;
    assign bus.fetch_fault = fault_r;
    assign bus.ld_ready    = ld_ready_r;
    assign bus.init_done   = init_done_r;
endmodule
